// File: rtl/qsn_shift_ctrl_if.sv
// Shift-factor stream into the QSN control stage: one circulant shift per column block.
interface qsn_shift_ctrl_if #(
  parameter int SEL_W = 8
);
  logic [SEL_W-1:0] shift_in;
  logic             shift_valid;
  logic             shift_ready;

  modport master (output shift_in, output shift_valid, input  shift_ready);
  modport slave  (input  shift_in, input  shift_valid, output shift_ready);
endinterface

// File: rtl/qsn_shift_ctrl.sv
// QSN control stage: turns per-column circulant shifts into left/right/merge select words
// and carries a latency-matched {valid, col, null} tag alongside the shifted vectors.

module qsn_merge_lane #(
  parameter int K = 0,
  parameter int W = 9
) (
  input  logic [W-1:0] thr,
  output logic         sel
);
  localparam logic [W-1:0] KW = W'(K);
  assign sel = (KW >= thr);
endmodule

module qsn_shift_ctrl #(
  parameter int Z         = 255,
  parameter int SEL_W     = 8,
  parameter int COL_NUM   = 3,
  parameter int QSN_LAT   = 2,
  parameter int NULL_CODE = 255
) (
  input  logic               sys_clk,
  input  logic               rstn,
  qsn_shift_ctrl_if.slave    sh,
  input  logic               layer_start,
  output logic [SEL_W-1:0]   left_sel,
  output logic [SEL_W-1:0]   right_sel,
  output logic [Z-2:0]       merge_sel,
  output logic               sw_in_en,
  output logic               out_valid,
  output logic [1:0]         out_col,
  output logic               out_null,
  output logic               layer_done,
  output logic               shift_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int             DW     = $clog2(QSN_LAT + 1);
  localparam logic [SEL_W:0] Z_W    = (SEL_W+1)'(Z);
  localparam logic [SEL_W-1:0] NULL_W = SEL_W'(NULL_CODE);
  localparam logic [1:0]     LAST_COL = 2'(COL_NUM - 1);
  localparam logic [DW-1:0]  DRAIN_END = DW'(QSN_LAT);

  logic [1:0]              state;
  logic [1:0]              col;
  logic [DW-1:0]           dcnt;
  logic [SEL_W-1:0]        s_eff;
  logic [QSN_LAT:0]        vld_pipe;
  logic [QSN_LAT:0][1:0]   col_pipe;
  logic [QSN_LAT:0]        null_pipe;

  logic hs, is_null, in_range, start_ok;
  logic [SEL_W:0] thr;

  assign sh.shift_ready = (state == S_RUN);
  assign hs       = sh.shift_valid && sh.shift_ready;
  assign is_null  = (sh.shift_in == NULL_W);
  assign in_range = ({1'b0, sh.shift_in} < Z_W);
  // a start coincident with layer_done belongs to the layer just finishing
  assign start_ok = layer_start && (state == S_IDLE) && !layer_done;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      col        <= '0;
      dcnt       <= '0;
      s_eff      <= '0;
      vld_pipe   <= '0;
      col_pipe   <= '0;
      null_pipe  <= '0;
      layer_done <= 1'b0;
      shift_err  <= 1'b0;
    end else begin
      layer_done  <= 1'b0;
      vld_pipe[0] <= hs;
      if (hs) begin
        s_eff        <= (in_range && !is_null) ? sh.shift_in : '0;
        null_pipe[0] <= !(in_range && !is_null);
        col_pipe[0]  <= col;
      end
      for (int i = 1; i <= QSN_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        col_pipe[i]  <= col_pipe[i-1];
        null_pipe[i] <= null_pipe[i-1];
      end

      if (hs && !in_range && !is_null) shift_err <= 1'b1;
      else if (start_ok)               shift_err <= 1'b0;

      case (state)
        S_IDLE: if (start_ok) begin
          state <= S_RUN;
          col   <= '0;
        end
        S_RUN: if (hs) begin
          col <= col + 2'd1;
          if (col == LAST_COL) begin
            state <= S_DRAIN;
            dcnt  <= '0;
          end
        end
        S_DRAIN: begin
          // last tag reaches the pipe output QSN_LAT cycles after its sw_in_en
          if (dcnt == DRAIN_END) begin
            layer_done <= 1'b1;
            state      <= S_IDLE;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign thr       = Z_W - {1'b0, s_eff};
  assign left_sel  = s_eff;
  assign right_sel = (s_eff == '0) ? '0 : thr[SEL_W-1:0];
  assign sw_in_en  = vld_pipe[0];

  // thermometer mask: lane k takes the left network when k >= Z - s
  for (genvar k = 0; k < Z - 1; k++) begin : g_merge
    qsn_merge_lane #(.K(k), .W(SEL_W + 1)) u_lane (
      .thr (thr),
      .sel (merge_sel[k])
    );
  end

  assign out_valid = vld_pipe[QSN_LAT] && !null_pipe[QSN_LAT];
  assign out_null  = vld_pipe[QSN_LAT] &&  null_pipe[QSN_LAT];
  assign out_col   = col_pipe[QSN_LAT];
endmodule

// File: tb/tb_qsn_shift_ctrl.sv
// Randomized bench for qsn_shift_ctrl with a timeline-based reference model (9-bit shift build).
module tb_qsn_shift_ctrl;
  localparam int Z = 255, SEL_W = 9, COL_NUM = 3, QSN_LAT = 2, NULL_CODE = 255;

  logic sys_clk, rstn, layer_start;
  logic [SEL_W-1:0] left_sel, right_sel;
  logic [Z-2:0] merge_sel;
  logic sw_in_en, out_valid, out_null, layer_done, shift_err;
  logic [1:0] out_col;

  qsn_shift_ctrl_if #(.SEL_W(SEL_W)) sh_if ();

  qsn_shift_ctrl #(.Z(Z), .SEL_W(SEL_W), .COL_NUM(COL_NUM), .QSN_LAT(QSN_LAT),
                   .NULL_CODE(NULL_CODE)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .sh(sh_if.slave), .layer_start(layer_start),
    .left_sel(left_sel), .right_sel(right_sel), .merge_sel(merge_sel),
    .sw_in_en(sw_in_en), .out_valid(out_valid), .out_col(out_col), .out_null(out_null),
    .layer_done(layer_done), .shift_err(shift_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0, errors = 0;
  int sh_a[3], gp_a[3];
  logic [SEL_W-1:0] m_left, m_right;
  logic [Z-2:0] m_merge;
  logic m_err;

  function automatic bit s_null(int s);
    return s >= Z;
  endfunction

  // s-1 lanes at the top of the mask take the left network
  function automatic logic [Z-2:0] exp_merge(int s);
    logic [Z-2:0] ones;
    ones = '1;
    if (s < 1 || s >= Z) return '0;
    return ~(ones >> (s - 1));
  endfunction

  // Runs one layer. Handshake i lands on edge h[i]; cycle c is the interval after edge c.
  task automatic run_layer(input int xstart);
    int h[3];
    int last, tag;
    logic en_e, ov_e, on_e, done_e, rdy_e;
    h[0] = 1 + gp_a[0];
    for (int i = 1; i < COL_NUM; i++) h[i] = h[i-1] + 1 + gp_a[i];
    last = h[COL_NUM-1] + QSN_LAT + 3;
    layer_start = 1'b1;
    @(posedge sys_clk); #1;
    layer_start = 1'b0;
    m_err = 1'b0;
    for (int c = 0; c <= last; c++) begin
      sh_if.shift_valid = 1'b0;
      sh_if.shift_in = SEL_W'($urandom_range(0, 511));
      for (int i = 0; i < COL_NUM; i++)
        if (h[i] == c + 1) begin
          sh_if.shift_valid = 1'b1;
          sh_if.shift_in = SEL_W'(sh_a[i]);
        end
      layer_start = (c == xstart);
      en_e = 1'b0; tag = -1;
      for (int i = 0; i < COL_NUM; i++) begin
        if (h[i] == c) begin
          en_e = 1'b1;
          m_left  = s_null(sh_a[i]) ? '0 : SEL_W'(sh_a[i]);
          m_right = (s_null(sh_a[i]) || sh_a[i] == 0) ? '0 : SEL_W'(Z - sh_a[i]);
          m_merge = exp_merge(sh_a[i]);
          if (sh_a[i] >= Z && sh_a[i] != NULL_CODE) m_err = 1'b1;
        end
        if (h[i] + QSN_LAT == c) tag = i;
      end
      ov_e = (tag >= 0) && !s_null(sh_a[tag >= 0 ? tag : 0]);
      on_e = (tag >= 0) &&  s_null(sh_a[tag >= 0 ? tag : 0]);
      done_e = (c == h[COL_NUM-1] + QSN_LAT + 1);
      rdy_e = (c < h[COL_NUM-1]);
      @(negedge sys_clk);
      checks += 9;
      if (sw_in_en !== en_e) begin errors++; $display("FAIL sw_in_en c%0d got %b exp %b", c, sw_in_en, en_e); end
      if (left_sel !== m_left) begin errors++; $display("FAIL left_sel c%0d got %0d exp %0d", c, left_sel, m_left); end
      if (right_sel !== m_right) begin errors++; $display("FAIL right_sel c%0d got %0d exp %0d", c, right_sel, m_right); end
      if (merge_sel !== m_merge) begin errors++; $display("FAIL merge_sel c%0d got %h exp %h", c, merge_sel, m_merge); end
      if (out_valid !== ov_e) begin errors++; $display("FAIL out_valid c%0d got %b exp %b", c, out_valid, ov_e); end
      if (out_null !== on_e) begin errors++; $display("FAIL out_null c%0d got %b exp %b", c, out_null, on_e); end
      if (layer_done !== done_e) begin errors++; $display("FAIL layer_done c%0d got %b exp %b", c, layer_done, done_e); end
      if (sh_if.shift_ready !== rdy_e) begin errors++; $display("FAIL shift_ready c%0d got %b exp %b", c, sh_if.shift_ready, rdy_e); end
      if (shift_err !== m_err) begin errors++; $display("FAIL shift_err c%0d got %b exp %b", c, shift_err, m_err); end
      if (tag >= 0) begin
        checks++;
        if (out_col !== 2'(tag)) begin errors++; $display("FAIL out_col c%0d got %0d exp %0d", c, out_col, tag); end
      end
      @(posedge sys_clk); #1;
    end
    sh_if.shift_valid = 1'b0;
    layer_start = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; layer_start = 1'b0;
    sh_if.shift_valid = 1'b0; sh_if.shift_in = '0;
    m_left = '0; m_right = '0; m_merge = '0; m_err = 1'b0;
    #12;
    checks += 5;
    if ({left_sel, right_sel} !== '0) begin errors++; $display("FAIL reset_sel got %h exp 0", {left_sel, right_sel}); end
    if (merge_sel !== '0) begin errors++; $display("FAIL reset_merge got %h exp 0", merge_sel); end
    if ({sw_in_en, out_valid, out_null, layer_done, shift_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {sw_in_en, out_valid, out_null, layer_done, shift_err});
    end
    if (out_col !== 2'd0) begin errors++; $display("FAIL reset_col got %0d exp 0", out_col); end
    if (sh_if.shift_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", sh_if.shift_ready); end
    @(negedge sys_clk); rstn = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_basic;
    sh_a = '{0, 1, 254}; gp_a = '{0, 0, 0};
    run_layer(-1);
  endtask

  task automatic test_null;
    sh_a = '{5, 255, 7}; gp_a = '{0, 0, 0};
    run_layer(-1);
  endtask

  task automatic test_illegal;
    sh_a = '{300, 12, 256}; gp_a = '{0, 1, 0};
    run_layer(-1);
    @(negedge sys_clk);
    checks++;
    if (shift_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", shift_err); end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_bubbles;
    sh_a = '{40, 100, 200}; gp_a = '{0, 2, 0};
    run_layer(-1);
  endtask

  task automatic test_ignored_start;
    sh_a = '{3, 4, 5}; gp_a = '{0, 0, 0};
    run_layer(3);
    sh_a = '{9, 255, 250}; gp_a = '{1, 0, 0};
    run_layer(7);
    sh_a = '{17, 0, 33}; gp_a = '{0, 0, 1};
    run_layer(1);
  endtask

  task automatic test_random;
    for (int l = 0; l < 8; l++) begin
      for (int i = 0; i < COL_NUM; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) sh_a[i] = NULL_CODE;
        else if (r == 1) sh_a[i] = $urandom_range(256, 511);
        else if (r == 2) sh_a[i] = 0;
        else sh_a[i] = $urandom_range(1, 254);
        gp_a[i] = $urandom_range(0, 2);
      end
      run_layer(($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : -1);
    end
  endtask

  task automatic test_reset_mid;
    layer_start = 1'b1;
    @(posedge sys_clk); #1;
    layer_start = 1'b0;
    sh_if.shift_valid = 1'b1; sh_if.shift_in = 9'd10;
    @(posedge sys_clk); #1;
    sh_if.shift_in = 9'd20;
    @(posedge sys_clk); #2;
    rstn = 1'b0;
    #1;
    m_left = '0; m_right = '0; m_merge = '0; m_err = 1'b0;
    checks += 4;
    if ({left_sel, right_sel} !== '0) begin errors++; $display("FAIL midrst_sel got %h exp 0", {left_sel, right_sel}); end
    if (merge_sel !== '0) begin errors++; $display("FAIL midrst_merge got %h exp 0", merge_sel); end
    if ({sw_in_en, out_valid, out_null, layer_done, shift_err} !== 5'b0) begin
      errors++; $display("FAIL midrst_flags got %b exp 00000", {sw_in_en, out_valid, out_null, layer_done, shift_err});
    end
    if (sh_if.shift_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", sh_if.shift_ready); end
    @(negedge sys_clk); rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      checks++;
      if ({out_valid, out_null, sw_in_en, sh_if.shift_ready} !== 4'b0) begin
        errors++; $display("FAIL post_rst c%0d got %b exp 0000", c, {out_valid, out_null, sw_in_en, sh_if.shift_ready});
      end
    end
    sh_if.shift_valid = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_null;
    test_illegal;
    test_bubbles;
    test_ignored_start;
    test_random;
    test_reset_mid;
    sh_a = '{128, 255, 1}; gp_a = '{2, 0, 1};
    run_layer(-1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
